// File: rtl/uart_host_pkg.sv
// Shared constants and types for the 8080-side UART host interface:
// register map, STATUS/CTRL bit positions and the TX launcher states.
package uart_host_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_STAT = 2'd1;
    localparam logic [1:0] ADDR_BLO  = 2'd2;
    localparam logic [1:0] ADDR_BHI  = 2'd3;

    // STATUS read bits
    localparam int unsigned ST_RX_AVAIL = 0;
    localparam int unsigned ST_TX_RDY   = 1;
    localparam int unsigned ST_RX_OVR   = 2;
    localparam int unsigned ST_TX_IDLE  = 3;
    localparam int unsigned ST_TX_OVF   = 4;
    localparam int unsigned ST_RX_IE    = 5;
    localparam int unsigned ST_TX_IE    = 6;

    // CTRL write bits
    localparam int unsigned CTL_RX_IE      = 0;
    localparam int unsigned CTL_TX_IE      = 1;
    localparam int unsigned CTL_CLR_RX_OVR = 2;
    localparam int unsigned CTL_CLR_TX_OVF = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } tx_state_t;

    function automatic logic [7:0] pack_status(
        input logic rx_avail,
        input logic tx_rdy,
        input logic rx_ovr,
        input logic tx_idle,
        input logic tx_ovf,
        input logic rx_ie,
        input logic tx_ie
    );
        logic [7:0] s;
        s              = 8'h00;
        s[ST_RX_AVAIL] = rx_avail;
        s[ST_TX_RDY]   = tx_rdy;
        s[ST_RX_OVR]   = rx_ovr;
        s[ST_TX_IDLE]  = tx_idle;
        s[ST_TX_OVF]   = tx_ovf;
        s[ST_RX_IE]    = rx_ie;
        s[ST_TX_IE]    = tx_ie;
        return s;
    endfunction

endpackage

// File: rtl/uart_host_if_if.sv
// 8080 I/O-port register bus between the CPU side (master) and the UART host block (slave).
interface uart_host_if_if;

    logic [1:0] addr;
    logic       wrEn;
    logic [7:0] wrData;
    logic       rdEn;
    logic [7:0] rdData;
    logic       irq;

    modport master (
        output addr,
        output wrEn,
        output wrData,
        output rdEn,
        input  rdData,
        input  irq
    );

    modport slave (
        input  addr,
        input  wrEn,
        input  wrData,
        input  rdEn,
        output rdData,
        output irq
    );

endinterface

// File: rtl/uart_host_if_sync_fifo.sv
// Show-ahead synchronous FIFO with AW+1 bit wrapping pointers; a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned Depth = 1 << AW;
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [Depth];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + PtrOne;
        if (do_pop)  rptr_d = rptr_q + PtrOne;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem_q[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_host_if.sv
// CPU register front end for the uart core: TX/RX byte FIFOs, TX launch handshake,
// baud divisor register and level interrupt.
module uart_host_if
    import uart_host_pkg::*;
#(
    parameter int unsigned FIFO_AW  = 4,
    parameter logic [15:0] BAUD_RST = 16'd26
) (
    input  logic                 clock,
    input  logic                 reset,
    uart_host_if_if.slave        bus,
    output logic [7:0]           txData,
    output logic                 txValid,
    input  logic                 txBusy,
    input  logic                 txDone,
    input  logic [7:0]           rxData,
    input  logic                 rxValid,
    output logic [15:0]          baudDiv
);

    tx_state_t   state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic [15:0] baud_q, baud_d;
    logic        rx_ovr_q, rx_ovr_d;
    logic        tx_ovf_q, tx_ovf_d;
    logic        rx_ie_q, rx_ie_d;
    logic        tx_ie_q, tx_ie_d;

    logic       wr_data, wr_ctrl, wr_blo, wr_bhi, rd_data_sel;
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_dout;
    logic       rx_pop_eff, rx_full, rx_empty;
    logic [7:0] rx_dout;
    logic       tx_idle;
    logic [7:0] status;

    assign wr_data     = bus.wrEn && (bus.addr == ADDR_DATA);
    assign wr_ctrl     = bus.wrEn && (bus.addr == ADDR_STAT);
    assign wr_blo      = bus.wrEn && (bus.addr == ADDR_BLO);
    assign wr_bhi      = bus.wrEn && (bus.addr == ADDR_BHI);
    assign rd_data_sel = bus.rdEn && (bus.addr == ADDR_DATA);

    assign tx_push    = wr_data && !tx_full;
    assign rx_pop_eff = rd_data_sel && !rx_empty;

    sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_tx_fifo (
        .clk   (clock),
        .rst   (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (bus.wrData),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_rx_fifo (
        .clk   (clock),
        .rst   (reset),
        .push  (rxValid),
        .pop   (rd_data_sel),
        .din   (rxData),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign tx_idle = tx_empty && (state_q == IDLE);
    assign status  = pack_status(!rx_empty, !tx_full, rx_ovr_q, tx_idle, tx_ovf_q,
                                 rx_ie_q, tx_ie_q);

    // TX launcher
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        tx_pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!tx_empty && !txBusy) begin
                    tx_pop     = 1'b1;
                    tx_data_d  = tx_dout;
                    tx_valid_d = 1'b1;
                    state_d    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: if (txBusy) state_d = WAIT_DONE;
            WAIT_DONE: if (txDone) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Registers; a set event wins over a clear in the same cycle.
    always_comb begin
        baud_d   = baud_q;
        rx_ie_d  = rx_ie_q;
        tx_ie_d  = tx_ie_q;
        rx_ovr_d = rx_ovr_q;
        tx_ovf_d = tx_ovf_q;
        if (wr_blo) baud_d[7:0]  = bus.wrData;
        if (wr_bhi) baud_d[15:8] = bus.wrData;
        if (wr_ctrl) begin
            rx_ie_d = bus.wrData[CTL_RX_IE];
            tx_ie_d = bus.wrData[CTL_TX_IE];
            if (bus.wrData[CTL_CLR_RX_OVR]) rx_ovr_d = 1'b0;
            if (bus.wrData[CTL_CLR_TX_OVF]) tx_ovf_d = 1'b0;
        end
        if (rxValid && rx_full && !rx_pop_eff) rx_ovr_d = 1'b1;
        if (wr_data && tx_full)                tx_ovf_d = 1'b1;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (bus.rdEn) begin
            unique case (bus.addr)
                ADDR_DATA: rd_data_d = rx_empty ? 8'h00 : rx_dout;
                ADDR_STAT: rd_data_d = status;
                ADDR_BLO:  rd_data_d = baud_q[7:0];
                ADDR_BHI:  rd_data_d = baud_q[15:8];
                default:   rd_data_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
            baud_q     <= BAUD_RST;
            rx_ovr_q   <= 1'b0;
            tx_ovf_q   <= 1'b0;
            rx_ie_q    <= 1'b0;
            tx_ie_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            rd_data_q  <= rd_data_d;
            baud_q     <= baud_d;
            rx_ovr_q   <= rx_ovr_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_ie_q    <= rx_ie_d;
            tx_ie_q    <= tx_ie_d;
        end
    end

    assign txData     = tx_data_q;
    assign txValid    = tx_valid_q;
    assign baudDiv    = baud_q;
    assign bus.rdData = rd_data_q;
    assign bus.irq    = (rx_ie_q && !rx_empty) || (tx_ie_q && tx_idle);

endmodule
